// File: rtl/jtag_ocimem_ctrl.sv
// OCI memory controller: turns JTAG ocimem strobes into single-word reads/writes
// on a wait-request port and reports MonDReg/MonAReg/monitor_ready/monitor_error.
module jtag_ocimem_ctrl #(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [37:0]       jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_no_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_read,
   output logic              mem_write,
   output logic [31:0]       mem_writedata,
   input  logic [31:0]       mem_readdata,
   input  logic              mem_waitrequest,
   output logic [31:0]       MonDReg,
   output logic [ADDR_W-1:0] MonAReg,
   output logic              monitor_ready,
   output logic              monitor_error
);

   localparam int              CNT_W       = 10;
   // Abort once the stall that brings the counter up to TIMEOUT has been seen.
   localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WR   = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_addr,  w_addr_nxt;
   logic [31:0]         r_dreg,  w_dreg_nxt;
   logic [31:0]         r_wdata, w_wdata_nxt;
   logic                r_rd,    w_rd_nxt;
   logic                r_wr,    w_wr_nxt;
   logic                r_ready, w_ready_nxt;
   logic                r_err,   w_err_nxt;
   logic [CNT_W-1:0]    r_cnt,   w_cnt_nxt;

   logic                w_any_strobe;
   logic                w_timeout;
   logic [ADDR_W-1:0]   w_jdo_addr;
   logic [31:0]         w_jdo_data;
   logic                w_unused_jdo;

   assign w_any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
   assign w_timeout    = mem_waitrequest && (r_cnt == LP_CNT_LAST);
   assign w_jdo_addr   = jdo[ADDR_W+1:2];
   assign w_jdo_data   = jdo[34:3];
   assign w_unused_jdo = ^{jdo[37:36], jdo[1:0]};

   // State and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_dreg  <= '0;
         r_wdata <= '0;
         r_rd    <= 1'b0;
         r_wr    <= 1'b0;
         r_ready <= 1'b1;
         r_err   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_addr  <= w_addr_nxt;
         r_dreg  <= w_dreg_nxt;
         r_wdata <= w_wdata_nxt;
         r_rd    <= w_rd_nxt;
         r_wr    <= w_wr_nxt;
         r_ready <= w_ready_nxt;
         r_err   <= w_err_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state decode; strobes are only honoured in IDLE, write has top priority
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (take_action_ocimem_b)
               w_state_nxt = S_WR;
            else if (take_action_ocimem_a && jdo[35])
               w_state_nxt = S_RD;
            else if (take_no_action_ocimem_a)
               w_state_nxt = S_RD;
         end
         S_RD, S_WR: begin
            if (!mem_waitrequest || w_timeout)
               w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Next values for the registered outputs
   always_comb begin
      w_addr_nxt  = r_addr;
      w_dreg_nxt  = r_dreg;
      w_wdata_nxt = r_wdata;
      w_rd_nxt    = r_rd;
      w_wr_nxt    = r_wr;
      w_ready_nxt = r_ready;
      w_err_nxt   = r_err;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (take_action_ocimem_b) begin
               w_wdata_nxt = w_jdo_data;
               w_dreg_nxt  = w_jdo_data;
               w_wr_nxt    = 1'b1;
               w_ready_nxt = 1'b0;
               w_err_nxt   = 1'b0;
               w_cnt_nxt   = '0;
            end else if (take_action_ocimem_a) begin
               w_addr_nxt = w_jdo_addr;
               w_err_nxt  = 1'b0;
               if (jdo[35]) begin
                  w_rd_nxt    = 1'b1;
                  w_ready_nxt = 1'b0;
                  w_cnt_nxt   = '0;
               end
            end else if (take_no_action_ocimem_a) begin
               w_rd_nxt    = 1'b1;
               w_ready_nxt = 1'b0;
               w_err_nxt   = 1'b0;
               w_cnt_nxt   = '0;
            end
         end
         S_RD, S_WR: begin
            // A strobe landing mid-access is an overrun; the access itself carries on.
            if (w_any_strobe)
               w_err_nxt = 1'b1;
            if (!mem_waitrequest) begin
               w_rd_nxt    = 1'b0;
               w_wr_nxt    = 1'b0;
               w_ready_nxt = 1'b1;
               w_addr_nxt  = r_addr + ADDR_W'(1);
               if (r_state == S_RD)
                  w_dreg_nxt = mem_readdata;
            end else if (w_timeout) begin
               w_rd_nxt    = 1'b0;
               w_wr_nxt    = 1'b0;
               w_ready_nxt = 1'b1;
               w_err_nxt   = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_rd_nxt    = 1'b0;
            w_wr_nxt    = 1'b0;
            w_ready_nxt = 1'b1;
         end
      endcase
   end

   assign mem_address   = r_addr;
   assign MonAReg       = r_addr;
   assign mem_read      = r_rd;
   assign mem_write     = r_wr;
   assign mem_writedata = r_wdata;
   assign MonDReg       = r_dreg;
   assign monitor_ready = r_ready;
   assign monitor_error = r_err;

endmodule
